// File: rtl/snake_disp_pkg.sv
// Shared definitions for the snake score display: game status codes, display
// states and special segment patterns.
package snake_disp_pkg;

  localparam logic [1:0] ST_RESTART = 2'b00;
  localparam logic [1:0] ST_START   = 2'b01;
  localparam logic [1:0] ST_PLAY    = 2'b10;
  localparam logic [1:0] ST_DIE     = 2'b11;

  typedef enum logic [1:0] {
    DispIdle,
    DispLive,
    DispBlink,
    DispFinal
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low seven-segment pattern {g..a};
// non-decimal nibbles show a dash.
module bcd_to_seg7
  import snake_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nibble)
      4'd0:    o_seg = 7'b1000000;
      4'd1:    o_seg = 7'b1111001;
      4'd2:    o_seg = 7'b0100100;
      4'd3:    o_seg = 7'b0110000;
      4'd4:    o_seg = 7'b0011001;
      4'd5:    o_seg = 7'b0010010;
      4'd6:    o_seg = 7'b0000010;
      4'd7:    o_seg = 7'b1111000;
      4'd8:    o_seg = 7'b0000000;
      4'd9:    o_seg = 7'b0010000;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/score_disp_ctrl.sv
// Four-digit score display sequencer with high-score register and digit scan.
// Optional leading-zero blanking is enabled by defining SCORE_LZ_BLANK_EN.
module score_disp_ctrl
  import snake_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 50000,
  parameter int unsigned BLINK_DIV   = 12500000,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  status,
  input  logic [15:0] score,
  output logic [6:0]  seg_out,
  output logic [3:0]  seg_con,
  output logic [15:0] hi_score,
  output logic        new_record
);

  localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned HALF_W  = $clog2(2 * BLINK_COUNT);

  disp_state_t         r_state, w_state_nxt;
  logic [SCAN_W-1:0]   r_scan_cnt, w_scan_cnt_nxt;
  logic [1:0]          r_idx, w_idx_nxt;
  logic [BLINK_W-1:0]  r_blink_cnt, w_blink_cnt_nxt;
  logic [HALF_W-1:0]   r_half_cnt, w_half_cnt_nxt;
  logic                r_blank, w_blank_nxt;
  logic [15:0]         r_hi, w_hi_nxt;
  logic [15:0]         r_final, w_final_nxt;
  logic                r_new_rec, w_new_rec_nxt;
  logic [6:0]          r_seg_out, w_seg_out_nxt;
  logic [3:0]          r_seg_con;

  logic                w_scan_wrap, w_blink_wrap, w_last_half, w_enter_blink;
  logic [15:0]         w_disp_val;
  logic [3:0]          w_nibble;
  logic [6:0]          w_seg_dec;
  logic                w_lz;

  always_comb begin
    w_scan_wrap    = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    w_scan_cnt_nxt = w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
    w_idx_nxt      = w_scan_wrap ? r_idx + 2'd1 : r_idx;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_blink_cnt_nxt = r_blink_cnt;
    w_half_cnt_nxt  = r_half_cnt;
    w_blank_nxt     = r_blank;
    w_hi_nxt        = r_hi;
    w_final_nxt     = r_final;
    w_new_rec_nxt   = r_new_rec;
    w_enter_blink   = 1'b0;
    w_blink_wrap    = (r_blink_cnt == BLINK_W'(BLINK_DIV - 1));
    w_last_half     = (r_half_cnt == HALF_W'(2 * BLINK_COUNT - 1));

    if (status == ST_RESTART) begin
      w_state_nxt = DispIdle;
    end else begin
      unique case (r_state)
        DispIdle: begin
          if (status == ST_DIE) begin
            w_enter_blink = 1'b1;
          end else begin
            w_state_nxt   = DispLive;
            w_new_rec_nxt = 1'b0;
          end
        end
        DispLive: begin
          if (status == ST_DIE) w_enter_blink = 1'b1;
        end
        DispBlink: begin
          if (w_blink_wrap) begin
            w_blink_cnt_nxt = '0;
            if (w_last_half) begin
              w_state_nxt = DispFinal;
            end else begin
              w_blank_nxt    = ~r_blank;
              w_half_cnt_nxt = r_half_cnt + 1'b1;
            end
          end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
          end
        end
        DispFinal: ;
      endcase
    end

    if (w_enter_blink) begin
      w_state_nxt     = DispBlink;
      w_blink_cnt_nxt = '0;
      w_half_cnt_nxt  = '0;
      w_blank_nxt     = 1'b0;
      w_final_nxt     = score;
      if (score > r_hi) begin
        w_hi_nxt      = score;
        w_new_rec_nxt = 1'b1;
      end else begin
        w_new_rec_nxt = 1'b0;
      end
    end
  end

  // Display content is taken from next-state values so seg_out and seg_con
  // move together on the same edge.
  always_comb begin
    unique case (w_state_nxt)
      DispIdle:  w_disp_val = w_hi_nxt;
      DispLive:  w_disp_val = score;
      default:   w_disp_val = w_final_nxt;
    endcase
    w_nibble = w_disp_val[{w_idx_nxt, 2'b00} +: 4];
`ifdef SCORE_LZ_BLANK_EN
    unique case (w_idx_nxt)
      2'd0: w_lz = 1'b0;
      2'd1: w_lz = (w_disp_val[15:4] == 12'h000);
      2'd2: w_lz = (w_disp_val[15:8] == 8'h00);
      2'd3: w_lz = (w_disp_val[15:12] == 4'h0);
    endcase
`else
    w_lz = 1'b0;
`endif
    if ((w_state_nxt == DispBlink && w_blank_nxt) || w_lz) w_seg_out_nxt = SEG_BLANK;
    else                                                   w_seg_out_nxt = w_seg_dec;
  end

  bcd_to_seg7 u_dec (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= DispIdle;
      r_scan_cnt  <= '0;
      r_idx       <= 2'd0;
      r_blink_cnt <= '0;
      r_half_cnt  <= '0;
      r_blank     <= 1'b0;
      r_hi        <= 16'h0000;
      r_final     <= 16'h0000;
      r_new_rec   <= 1'b0;
      r_seg_out   <= SEG_BLANK;
      r_seg_con   <= 4'b1111;
    end else begin
      r_state     <= w_state_nxt;
      r_scan_cnt  <= w_scan_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_blink_cnt <= w_blink_cnt_nxt;
      r_half_cnt  <= w_half_cnt_nxt;
      r_blank     <= w_blank_nxt;
      r_hi        <= w_hi_nxt;
      r_final     <= w_final_nxt;
      r_new_rec   <= w_new_rec_nxt;
      r_seg_out   <= w_seg_out_nxt;
      r_seg_con   <= ~(4'b0001 << w_idx_nxt);
    end
  end

  assign seg_out    = r_seg_out;
  assign seg_con    = r_seg_con;
  assign hi_score   = r_hi;
  assign new_record = r_new_rec;

endmodule
